// File: rtl/spm_port_queue_pkg.sv
// Shared types and constants for the scratch-pad requester ports.
// Bank selection uses address bits [3:2] across the four banks.
package spm_port_queue_pkg;

  localparam int unsigned SPM_NUM_PORTS    = 5;
  localparam int unsigned SPM_BANK_SEL_LSB = 2;
  localparam int unsigned SPM_RESP_LATENCY = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memory_request_t;

  function automatic logic [1:0] bank_sel(input logic [31:0] addr);
    return addr[SPM_BANK_SEL_LSB +: 2];
  endfunction

endpackage

// File: rtl/spm_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head is a combinational read of storage.
module spm_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty   = (wptr_q == rptr_q);
    count   = wptr_q - rptr_q;
    rdata   = mem_q[rptr_q[AW-1:0]];
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage holds no reset state; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spm_port_queue.sv
// Per-requester ingress queue for the scratch pad: buffers requests, holds the head on the bank
// arbiters until granted, tracks outstanding requests and returns in-order responses.
module spm_port_queue
  import spm_port_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  memory_request_t   in_req,
  output logic              out_valid,
  output memory_request_t   out_req,
  input  logic              out_grant,
  input  logic              bank_rvalid,
  input  logic [DATA_W-1:0] bank_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        outstanding,
  output logic              starve,
  output logic              err_unexpected
);

  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned ReqW    = $bits(memory_request_t);
  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic [ReqW-1:0]   fifo_head;
  logic              push, pop, accept, unexpected;

  logic [2:0]        outstanding_q, outstanding_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  spm_fifo #(
    .WIDTH (ReqW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_req),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    in_ready   = fifo_count < CntW'(DEPTH);
    push       = in_valid && in_ready;
    out_valid  = !fifo_empty && (outstanding_q < 3'(MAX_OUT));
    out_req    = memory_request_t'(fifo_head);
    pop        = out_valid && out_grant;
    accept     = bank_rvalid && (outstanding_q != 3'd0);
    // Responses still in flight from before reset land in the first cycle and are not errors.
    unexpected = bank_rvalid && (outstanding_q == 3'd0) && !first_q;

    outstanding_d = outstanding_q;
    if (pop && !accept) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (accept && !pop) begin
      outstanding_d = outstanding_q - 3'd1;
    end

    // A block due to MAX_OUT drops out_valid and therefore is not counted as starvation.
    starve_cnt_d = starve_cnt_q;
    if (!out_valid || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    err_d        = err_q || unexpected;
    first_d      = 1'b0;
    resp_valid_d = accept;
    resp_data_d  = accept ? bank_rdata : resp_data_q;

    resp_valid     = resp_valid_q;
    resp_data      = resp_data_q;
    outstanding    = outstanding_q;
    starve         = (starve_cnt_q == StarveMax);
    err_unexpected = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      starve_cnt_q  <= '0;
      err_q         <= 1'b0;
      first_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      starve_cnt_q  <= starve_cnt_d;
      err_q         <= err_d;
      first_q       <= first_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
    end
  end

  a_full_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == CntW'(DEPTH)));
  a_outstanding_bound : assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_q <= 3'(MAX_OUT));

endmodule

// File: tb/tb_spm_port_queue.sv
// Scenario bench for spm_port_queue: expected response data is queued when the bank
// response is driven and compared when the client response appears.
module tb_spm_port_queue;
  import spm_port_queue_pkg::*;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned MAX_OUT      = 2;
  localparam int unsigned STARVE_LIMIT = 64;
  localparam int unsigned DATA_W       = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  memory_request_t   in_req;
  logic              out_valid;
  memory_request_t   out_req;
  logic              out_grant;
  logic              bank_rvalid;
  logic [DATA_W-1:0] bank_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [2:0]        outstanding;
  logic              starve;
  logic              err_unexpected;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] sb_exp;

  always #5 clk = ~clk;

  spm_port_queue #(
    .DEPTH        (DEPTH),
    .MAX_OUT      (MAX_OUT),
    .STARVE_LIMIT (STARVE_LIMIT),
    .DATA_W       (DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_req         (in_req),
    .out_valid      (out_valid),
    .out_req        (out_req),
    .out_grant      (out_grant),
    .bank_rvalid    (bank_rvalid),
    .bank_rdata     (bank_rdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .outstanding    (outstanding),
    .starve         (starve),
    .err_unexpected (err_unexpected)
  );

  function automatic memory_request_t mk_req(input logic [31:0] a);
    memory_request_t r;
    r.addr  = a;
    r.we    = a[4];
    r.be    = 4'hF;
    r.wdata = ~a;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every client response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL resp_extra: got resp_data=%h, required no response", resp_data);
      end else begin
        sb_exp = sb.pop_front();
        if (resp_data !== sb_exp) begin
          n_bad++;
          $display("FAIL resp_data: got %h, required %h", resp_data, sb_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_req = mk_req(32'h99);
    out_grant = 1'b0; bank_rvalid = 1'b0; bank_rdata = '0;
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, resp_valid, starve, err_unexpected} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_flags: got rdy/ov/rv/st/err=%b, required 10000",
               {in_ready, out_valid, resp_valid, starve, err_unexpected});
    end
    n_cmp++;
    if (outstanding !== 3'd0 || resp_data !== '0) begin
      n_bad++;
      $display("FAIL reset_counts: got outstanding=%0d resp_data=%h, required 0 0",
               outstanding, resp_data);
    end
    cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_push: got out_valid=%b, required 0", out_valid);
    end
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_req = mk_req(32'h10 * (i + 1));
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_ready_%0d: got in_ready=%b, required 1", i, in_ready);
      end
      cyc();
    end
    in_req = mk_req(32'h50);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_req !== mk_req(32'h10)) begin
      n_bad++;
      $display("FAIL fill_full: got in_ready=%b out_valid=%b addr=%h, required 0 1 00000010",
               in_ready, out_valid, out_req.addr);
    end
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      out_grant = (k < 4); bank_rvalid = (k >= 1); bank_rdata = 32'hF00 + k;
      if (k >= 1) sb.push_back(32'hF00 + k);
      @(negedge clk);
      n_cmp++;
      if (k < 4 && (out_valid !== 1'b1 || out_req !== mk_req(32'h10 * (k + 1)))) begin
        n_bad++;
        $display("FAIL fill_order_%0d: got out_valid=%b addr=%h, required 1 %h",
                 k, out_valid, out_req.addr, 32'h10 * (k + 1));
      end else if (k == 4 && out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_fifth_held: got out_valid=%b, required 0", out_valid);
      end
      cyc();
    end
    out_grant = 1'b0; bank_rvalid = 1'b0;
    cyc();
  endtask

  task automatic test_grant_stream();
    logic [2:0] peak;
    peak = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_req = mk_req(32'hA0 + 32'h10 * i);
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      out_grant = (k < 3); bank_rvalid = (k >= 1); bank_rdata = 32'h9 + k;
      if (k >= 1) sb.push_back(32'h9 + k);
      @(negedge clk);
      if (outstanding > peak) peak = outstanding;
      if (k < 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_req !== mk_req(32'hA0 + 32'h10 * k)) begin
          n_bad++;
          $display("FAIL stream_head_%0d: got out_valid=%b addr=%h", k, out_valid, out_req.addr);
        end
      end
      cyc();
    end
    out_grant = 1'b0; bank_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (peak !== 3'd1 || outstanding !== 3'd0) begin
      n_bad++;
      $display("FAIL stream_outstanding: got peak=%0d final=%0d, required 1 0", peak, outstanding);
    end
    cyc();
  endtask

  task automatic test_max_out();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_req = mk_req(32'h100 * (i + 1));
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out_grant = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL maxout_grant_%0d: got out_valid=%b, required 1", k, out_valid);
      end
      cyc();
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || outstanding !== 3'd2) begin
      n_bad++;
      $display("FAIL maxout_block: got out_valid=%b outstanding=%0d, required 0 2",
               out_valid, outstanding);
    end
    cyc();
    out_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (starve !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL maxout_no_starve_%0d: got starve=%b out_valid=%b, required 0 0",
                 k, starve, out_valid);
      end
      cyc();
    end
    bank_rvalid = 1'b1; bank_rdata = 32'h111; sb.push_back(32'h111);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL maxout_same_cycle: got out_valid=%b, required 0", out_valid);
    end
    cyc();
    out_grant = 1'b1; bank_rdata = 32'h222; sb.push_back(32'h222);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || outstanding !== 3'd1) begin
      n_bad++;
      $display("FAIL maxout_release: got out_valid=%b outstanding=%0d, required 1 1",
               out_valid, outstanding);
    end
    cyc();
    out_grant = 1'b0; bank_rdata = 32'h333; sb.push_back(32'h333);
    cyc();
    bank_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outstanding !== 3'd0) begin
      n_bad++;
      $display("FAIL maxout_drain: got outstanding=%0d, required 0", outstanding);
    end
    cyc();
  endtask

  task automatic test_starve();
    in_valid = 1'b1; in_req = mk_req(32'h400);
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i <= STARVE_LIMIT; i++) begin
      @(negedge clk);
      if (i == STARVE_LIMIT) begin
        n_cmp++;
        if (starve !== 1'b0) begin
          n_bad++;
          $display("FAIL starve_early: got starve=%b at cycle %0d, required 0", starve, i);
        end
      end
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (starve !== 1'b1) begin
        n_bad++;
        $display("FAIL starve_set_%0d: got starve=%b, required 1", k, starve);
      end
      cyc();
    end
    out_grant = 1'b1;
    cyc();
    out_grant = 1'b0; bank_rvalid = 1'b1; bank_rdata = 32'h44; sb.push_back(32'h44);
    @(negedge clk);
    n_cmp++;
    if (starve !== 1'b0) begin
      n_bad++;
      $display("FAIL starve_clear: got starve=%b, required 0", starve);
    end
    cyc();
    bank_rvalid = 1'b0;
    cyc();
  endtask

  task automatic test_errors();
    bank_rvalid = 1'b1; bank_rdata = 32'hDEAD;
    @(negedge clk);
    n_cmp++;
    if (err_unexpected !== 1'b0) begin
      n_bad++;
      $display("FAIL err_before: got err_unexpected=%b, required 0", err_unexpected);
    end
    cyc();
    bank_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (err_unexpected !== 1'b1) begin
        n_bad++;
        $display("FAIL err_sticky_%0d: got err_unexpected=%b, required 1", k, err_unexpected);
      end
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (err_unexpected !== 1'b0) begin
      n_bad++;
      $display("FAIL err_reset_clear: got err_unexpected=%b, required 0", err_unexpected);
    end
    in_valid = 1'b1; in_req = mk_req(32'h500);
    cyc();
    in_req = mk_req(32'h600); out_grant = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    out_grant = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outstanding !== 3'd2) begin
      n_bad++;
      $display("FAIL err_burst_out: got outstanding=%0d, required 2", outstanding);
    end
    rst_n = 1'b0; bank_rvalid = 1'b1; bank_rdata = 32'hBAD1;
    cyc();
    rst_n = 1'b1; bank_rdata = 32'hBAD2;
    cyc();
    bank_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_unexpected !== 1'b0 || resp_valid !== 1'b0 || outstanding !== 3'd0) begin
      n_bad++;
      $display("FAIL err_late_drop: got err=%b resp_valid=%b outstanding=%0d, required 0 0 0",
               err_unexpected, resp_valid, outstanding);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_grant_stream();
    test_max_out();
    test_starve();
    test_errors();
    cyc();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL resp_missing: got %0d responses still pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
